// File: rtl/duc_nco_mixer.sv
// Final DUC stage: multiplies the interpolated real sample stream by an NCO cosine carrier.
// Three lock-step pipeline stages with valid/ready backpressure carried straight through.
module duc_nco_mixer #(
  parameter int IN_WIDTH   = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LUT_ADDR_W = 10,
  parameter int AMP_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 bypass,
  input  logic [ACC_WIDTH-1:0] freq_word,
  input  logic                 phase_clr,
  input  logic [IN_WIDTH-1:0]  src_data_in,
  input  logic                 src_valid_in,
  output logic                 src_ready_out,
  output logic [IN_WIDTH-1:0]  dst_data_out,
  output logic                 dst_valid_out,
  input  logic                 dst_ready_in
);

  localparam int  PW        = IN_WIDTH + AMP_WIDTH;
  localparam int  LUT_DEPTH = 1 << LUT_ADDR_W;
  localparam real PI        = 3.14159265358979323846;
  localparam real AMP_R     = real'((1 << (AMP_WIDTH - 1)) - 1);

  localparam logic signed [PW-1:0] RND  = PW'(1) << (AMP_WIDTH - 2);
  localparam logic signed [PW-1:0] YMAX = (PW'(1) << (IN_WIDTH - 1)) - PW'(1);
  localparam logic signed [PW-1:0] YMIN = -YMAX - PW'(1);

  // Cosine ROM built at elaboration, rounded half away from zero.
  logic signed [AMP_WIDTH-1:0] lut [LUT_DEPTH];
  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam real V  = AMP_R * $cos(2.0 * PI * real'(k) / real'(LUT_DEPTH));
    localparam int  VI = (V >= 0.0) ? $rtoi(V + 0.5) : -$rtoi(0.5 - V);
    assign lut[k] = AMP_WIDTH'(VI);
  end

  logic [ACC_WIDTH-1:0]        acc;
  logic                        advance;
  logic                        handshake;

  logic                        s1_valid, s2_valid, s3_valid;
  logic                        s1_bypass, s2_bypass;
  logic signed [IN_WIDTH-1:0]  s1_data, s2_data, s3_data;
  logic [LUT_ADDR_W-1:0]       s1_addr;
  logic signed [AMP_WIDTH-1:0] s2_lut;

  logic signed [PW-1:0]        prod, y_full;
  logic                        sat_hi, sat_lo;
  logic signed [IN_WIDTH-1:0]  y_sat;

  assign advance       = ~s3_valid | dst_ready_in;
  assign handshake     = src_valid_in & advance;
  assign src_ready_out = advance;
  assign dst_valid_out = s3_valid;
  assign dst_data_out  = s3_data;

  always_comb begin
    prod   = s2_data * s2_lut;
    y_full = (prod + RND) >>> (AMP_WIDTH - 1);
    sat_hi = y_full > YMAX;
    sat_lo = y_full < YMIN;
    if (sat_hi)      y_sat = {1'b0, {(IN_WIDTH-1){1'b1}}};
    else if (sat_lo) y_sat = {1'b1, {(IN_WIDTH-1){1'b0}}};
    else             y_sat = y_full[IN_WIDTH-1:0];
  end

  // Clear beats add: a coincident sample still takes the pre-clear phase via s1_addr.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)        acc <= '0;
    else if (phase_clr) acc <= '0;
    else if (handshake) acc <= acc + freq_word;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_valid  <= 1'b0;
      s1_bypass <= 1'b0;
      s1_data   <= '0;
      s1_addr   <= '0;
      s2_valid  <= 1'b0;
      s2_bypass <= 1'b0;
      s2_data   <= '0;
      s2_lut    <= '0;
      s3_valid  <= 1'b0;
      s3_data   <= '0;
    end else if (advance) begin
      s1_valid  <= src_valid_in;
      s1_bypass <= bypass;
      s1_data   <= src_data_in;
      s1_addr   <= acc[ACC_WIDTH-1 -: LUT_ADDR_W];
      s2_valid  <= s1_valid;
      s2_bypass <= s1_bypass;
      s2_data   <= s1_data;
      s2_lut    <= lut[s1_addr];
      s3_valid  <= s2_valid;
      s3_data   <= s2_bypass ? s2_data : y_sat;
    end
  end

  a_no_sat: assert property (@(posedge clk) disable iff (!arst_n)
    (advance && s2_valid && !s2_bypass) |-> !(sat_hi || sat_lo))
    else $error("duc_nco_mixer: mixer output saturated");

endmodule

// File: tb/tb_duc_nco_mixer.sv
// Scoreboard bench for duc_nco_mixer: a behavioural NCO/mixer model queues expected beats on
// each input handshake; the output monitor pops and compares on each output handshake.
module tb_duc_nco_mixer;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        bypass = 1'b0;
  logic [31:0] freq_word = '0;
  logic        phase_clr = 1'b0;
  logic [15:0] src_data_in = '0;
  logic        src_valid_in = 1'b0;
  logic        src_ready_out;
  logic [15:0] dst_data_out;
  logic        dst_valid_out;
  logic        dst_ready_in = 1'b1;

  duc_nco_mixer #(.IN_WIDTH(16), .ACC_WIDTH(32), .LUT_ADDR_W(10), .AMP_WIDTH(16)) dut (
    .clk(clk), .arst_n(arst_n), .bypass(bypass), .freq_word(freq_word), .phase_clr(phase_clr),
    .src_data_in(src_data_in), .src_valid_in(src_valid_in), .src_ready_out(src_ready_out),
    .dst_data_out(dst_data_out), .dst_valid_out(dst_valid_out), .dst_ready_in(dst_ready_in)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int cyc; } exp_t;
  exp_t        sb[$];
  int          out_log[$];
  int          exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  logic [31:0] macc = '0;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int model_lut(input int k);
    real v;
    v = 32767.0 * $cos(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic int model_mix(input int d, input int c);
    longint y;
    y = ((longint'(d) * longint'(c)) + 64'sd16384) >>> 15;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return int'(y);
  endfunction

  // Model: NCO phase and expected sample at every accepted input.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      macc = '0;
      sb.delete();
    end else begin
      int d;
      bit hs;
      cyc = cyc + 1;
      hs = src_valid_in && src_ready_out;
      if (hs) begin
        d = int'($signed(src_data_in));
        sb.push_back('{bypass ? d : model_mix(d, model_lut(int'(macc[31:22]))), cyc});
      end
      if (phase_clr) macc = '0;
      else if (hs)   macc = macc + freq_word;
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    int   act;
    act = int'($signed(dst_data_out));
    if (arst_n && dst_valid_out) begin
      if (dst_ready_in) begin
        if (sb.size() == 0) check("spurious_beat", 1, 0);
        else begin
          e = sb.pop_front();
          check("data", act, e.data);
          out_log.push_back(act);
          if (lat_chk) check("latency", cyc + 1 - e.cyc, 3);
        end
      end else if (sb.size() != 0) begin
        check("stall_hold", act, sb[0].data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int d, input bit byp);
    bit r;
    int n;
    src_data_in  = 16'(d);
    bypass       = byp;
    src_valid_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk); r = src_ready_out;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 50);
    if (!r) check("send_timeout", 0, 1);
    src_valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin tick(1); n++; end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    tick(3);
  endtask

  task automatic clear_phase();
    phase_clr = 1'b1; tick(1); phase_clr = 1'b0;
  endtask

  task automatic check_log(input string tag, input int exp[$]);
    check({tag, "_count"}, out_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < out_log.size(); i++)
      check(tag, out_log[i], exp[i]);
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_valid", int'(dst_valid_out), 0);
    check("rst_data", int'(dst_data_out), 0);
    arst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", int'(src_ready_out), 1);
    tick(1);

    // Zero carrier frequency: constant 1000 passes at full gain, latency 3
    lat_chk = 1'b1; out_log.delete();
    for (int i = 0; i < 6; i++) send(1000, 1'b0);
    drain();
    exp_q = '{1000, 1000, 1000, 1000, 1000, 1000};
    check_log("dc_seq", exp_q);

    // Quarter-turn carrier
    freq_word = 32'h4000_0000; clear_phase(); out_log.delete();
    for (int i = 0; i < 8; i++) send(1000, 1'b0);
    drain();
    exp_q = '{1000, 0, -1000, 0, 1000, 0, -1000, 0};
    check_log("quarter_seq", exp_q);

    // Full-scale extremes; 32767*32767 rounds to 32766 under the (p+2^14)>>>15 rule
    freq_word = '0; clear_phase(); out_log.delete();
    send(-32768, 1'b0); send(32767, 1'b0);
    drain();
    exp_q = '{-32767, 32766};
    check_log("extreme_seq", exp_q);

    // Downstream stall of 5 cycles mid-stream
    lat_chk = 1'b0;
    freq_word = 32'h4000_0000; clear_phase(); out_log.delete();
    fork
      for (int i = 0; i < 8; i++) send(1000, 1'b0);
      begin tick(5); dst_ready_in = 1'b0; tick(5); dst_ready_in = 1'b1; end
    join
    drain();
    exp_q = '{1000, 0, -1000, 0, 1000, 0, -1000, 0};
    check_log("stall_seq", exp_q);

    // Phase clear pulse between the 3rd and 4th samples
    clear_phase(); out_log.delete();
    for (int i = 0; i < 3; i++) send(1000, 1'b0);
    clear_phase();
    for (int i = 0; i < 2; i++) send(1000, 1'b0);
    drain();
    exp_q = '{1000, 0, -1000, 1000, 0};
    check_log("clr_seq", exp_q);

    // Phase clear coincident with the 3rd handshake: that sample keeps the old phase
    clear_phase(); out_log.delete();
    send(1000, 1'b0); send(1000, 1'b0);
    phase_clr = 1'b1; send(1000, 1'b0); phase_clr = 1'b0;
    send(1000, 1'b0); send(1000, 1'b0);
    drain();
    exp_q = '{1000, 0, -1000, 1000, 0};
    check_log("clr_coinc_seq", exp_q);

    // Bypass ramp with random input gaps
    lat_chk = 1'b1; out_log.delete();
    for (int i = 1; i <= 6; i++) begin
      send(i, 1'b1);
      tick($urandom_range(0, 2));
    end
    drain();
    exp_q = '{1, 2, 3, 4, 5, 6};
    check_log("bypass_seq", exp_q);
    lat_chk = 1'b0;

    // Async reset with samples in flight: nothing emitted, phase restarts
    send(-500, 1'b0); send(700, 1'b0);
    arst_n = 1'b0;
    #2;
    check("midrst_valid", int'(dst_valid_out), 0);
    out_log.delete();
    tick(2);
    arst_n = 1'b1;
    tick(1);
    send(1000, 1'b0); send(1000, 1'b0);
    drain();
    exp_q = '{1000, 0};
    check_log("post_rst_seq", exp_q);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench time limit reached");
  end

endmodule
